// File: rtl/dmem_line_responder_if.sv
// Line-request bus between the dcache controller and the backing memory.
// Stats ports exist only when MEM_RESP_STATS_EN is defined.
interface dmem_line_responder_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;
`ifdef MEM_RESP_STATS_EN
  logic [15:0]       rd_cnt_o;
  logic [15:0]       wr_cnt_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o, rd_cnt_o, wr_cnt_o
  );
  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o, rd_cnt_o, wr_cnt_o
  );
`else
  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o
  );
  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o
  );
`endif
endinterface

// File: rtl/dmem_line_responder.sv
// Fixed-latency line memory below the dcache: IDLE -> WAIT -> ACK.
// Optional MEM_RESP_STATS_EN adds saturating read/write completion counters.
module dmem_line_responder #(
  parameter int LATENCY  = 10,
  parameter int DEPTH    = 512,
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  dmem_line_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  logic [LINE_W-1:0] memory [DEPTH];

  logic [1:0]        r_state;
  logic [7:0]        r_cnt;
  logic              r_ack;
  logic [LINE_W-1:0] r_rdata;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic [LINE_W-1:0] r_wdata;

  logic [IDX_W-1:0]  w_idx;
  logic              w_done;
  logic              w_commit;

  assign w_idx    = bus.addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
  assign w_done   = (r_state == S_WAIT) && (r_cnt == 8'd0);
  assign w_commit = !rst_i && w_done && r_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (bus.enable_i) begin
            r_state <= S_WAIT;
            r_cnt   <= LAT_M1;
            r_idx   <= w_idx;
            r_we    <= bus.write_i;
            r_wdata <= bus.data_i;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            if (!r_we) r_rdata <= memory[r_idx];
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Array is never reset; an aborted write never reaches it.
  always_ff @(posedge clk_i) begin
    if (w_commit) memory[r_idx] <= r_wdata;
  end

  assign bus.ack_o  = r_ack;
  assign bus.data_o = r_rdata;
  assign bus.busy_o = (r_state != S_IDLE);

`ifdef MEM_RESP_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_done) begin
      if (r_we) begin
        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      end else begin
        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  assign bus.rd_cnt_o = r_rd_cnt;
  assign bus.wr_cnt_o = r_wr_cnt;
`endif
endmodule

// File: tb/tb_dmem_line_responder.sv
// Bench for dmem_line_responder: vector table, corner sequences, random vs model.
// Stats counters are checked when MEM_RESP_STATS_EN is defined.
module tb_dmem_line_responder;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_line_responder_if bus ();
  dmem_line_responder_if bus1 ();

  dmem_line_responder #(.LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  dmem_line_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic [255:0] exp;
  } vec_t;

  vec_t vt[8];

  logic [255:0] mdl [512];
  logic [255:0] last_rd;
  int n_rd, n_wr;
  int pass_cnt = 0;
  int total = 0;

  function automatic logic [255:0] pre(input int i);
    logic [255:0] p;
    p = 256'(i);
    return p * 256'd7 + 256'd5;
  endfunction

  function automatic int lidx(input logic [31:0] a);
    return int'((a >> 5) % 512);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic req(input bit wr, input logic [31:0] a,
                     input logic [255:0] d, input bit scr,
                     output int lat);
    bit busy_ok;
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.data_i   = d;
    @(posedge clk);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (!bus.busy_o) busy_ok = 1'b0;
      if (bus.ack_o) begin
        lat = k;
        break;
      end
      if (scr) begin
        bus.enable_i = 1'($urandom_range(0, 1));
        bus.write_i  = 1'($urandom_range(0, 1));
        bus.addr_i   = $urandom;
        bus.data_i   = {8{$urandom}};
      end
    end
    bus.enable_i = 1'b0;
    chk("busy_in_flight", 256'(busy_ok), 256'd1);
  endtask

  task automatic run(input string tag, input bit wr, input logic [31:0] a,
                     input logic [255:0] d, input bit scr,
                     input logic [255:0] exp);
    int lat;
    req(wr, a, d, scr, lat);
    chk({tag, "_lat"}, 256'(lat), 256'(LAT));
    chk({tag, "_data"}, bus.data_o, exp);
    if (wr) begin
      mdl[lidx(a)] = d;
      n_wr++;
    end else begin
      last_rd = mdl[lidx(a)];
      n_rd++;
    end
    @(posedge clk); #1;
    chk({tag, "_ackdrop"}, 256'({bus.ack_o, bus.busy_o}), 256'd0);
  endtask

  initial begin
    int acks, t1, t2;
    logic [255:0] db, pa, e;
    logic [31:0] a;
    bit wr;

    db = {8{32'hDEADBEEF}};
    pa = {4{64'h0123456789ABCDEF}};
    bus.enable_i = 0; bus.write_i = 0; bus.addr_i = 0; bus.data_i = 0;
    bus1.enable_i = 0; bus1.write_i = 0; bus1.addr_i = 0; bus1.data_i = 0;
    for (int i = 0; i < 512; i++) begin
      dut.memory[i] = pre(i);
      mdl[i] = pre(i);
    end
    dut1.memory[0] = 256'h5;
    last_rd = '0;
    n_rd = 0;
    n_wr = 0;

    vt[0] = '{0, 32'h0000_0000, '0, 256'h5};
    vt[1] = '{1, 32'h0000_0420, db, 256'h5};
    vt[2] = '{0, 32'h0000_0420, '0, db};
    vt[3] = '{0, 32'h0000_4420, '0, db};
    vt[4] = '{0, 32'h0000_043F, '0, db};
    vt[5] = '{1, 32'h0000_3FE0, pa, db};
    vt[6] = '{0, 32'hFFFF_FFE0, '0, pa};
    vt[7] = '{0, 32'h0000_0040, '0, 256'd19};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 256'(bus.ack_o), 256'd0);
    chk("rst_data", bus.data_o, 256'd0);
    chk("rst_busy", 256'(bus.busy_o), 256'd0);
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=1 instance: ack on the edge right after accept
    @(negedge clk);
    bus1.enable_i = 1'b1;
    @(posedge clk); #1;
    chk("l1_t0", 256'({bus1.ack_o, bus1.busy_o}), 256'b01);
    bus1.enable_i = 1'b0;
    @(posedge clk); #1;
    chk("l1_ack", 256'({bus1.ack_o, bus1.busy_o}), 256'b11);
    chk("l1_data", bus1.data_o, 256'h5);
    @(posedge clk); #1;
    chk("l1_idle", 256'({bus1.ack_o, bus1.busy_o}), 256'b00);

    for (int i = 0; i < 8; i++)
      run($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wd, 1'b0,
          vt[i].exp);

    // enable held high across two reads
    @(negedge clk);
    bus.enable_i = 1'b1; bus.write_i = 1'b0; bus.addr_i = 32'h20;
    @(posedge clk);
    acks = 0; t1 = -1; t2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.ack_o) begin
        acks++;
        if (acks == 1) t1 = k;
        if (acks == 2) begin
          t2 = k;
          bus.enable_i = 1'b0;
        end
      end
    end
    chk("hold_acks", 256'(acks), 256'd2);
    chk("hold_t1", 256'(t1), 256'(LAT));
    chk("hold_t2", 256'(t2), 256'(2 * LAT + 2));
    chk("hold_data", bus.data_o, mdl[1]);
    last_rd = mdl[1];
    n_rd += 2;

    // reset and enable on the same edge
    @(negedge clk);
    rst = 1'b1; bus.enable_i = 1'b1; bus.write_i = 1'b1;
    bus.addr_i = 32'h40; bus.data_i = db;
    @(posedge clk); #1;
    chk("rst_en_busy", 256'(bus.busy_o), 256'd0);
    @(negedge clk);
    rst = 1'b0; bus.enable_i = 1'b0;
    last_rd = '0; n_rd = 0; n_wr = 0;
    acks = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (bus.ack_o || bus.busy_o) acks++;
    end
    chk("rst_en_quiet", 256'(acks), 256'd0);

    // reset in the middle of a write
    @(negedge clk);
    bus.enable_i = 1'b1; bus.write_i = 1'b1;
    bus.addr_i = 32'h40; bus.data_i = db;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; bus.enable_i = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", 256'({bus.ack_o, bus.busy_o}), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.ack_o) acks++;
    end
    chk("abort_noack", 256'(acks), 256'd0);
    chk("abort_data0", bus.data_o, 256'd0);
    run("abort_rd", 1'b0, 32'h40, '0, 1'b0, 256'd19);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = {18'($urandom), 9'($urandom_range(0, 511)), 5'($urandom)};
      if (i % 4 == 0) a[13:5] = 9'(i / 4);
      e = wr ? last_rd : mdl[lidx(a)];
      run($sformatf("rnd%0d", i), wr, a, {8{$urandom}}, 1'b1, e);
    end

`ifdef MEM_RESP_STATS_EN
    chk("stat_rd", 256'(bus.rd_cnt_o), 256'(n_rd));
    chk("stat_wr", 256'(bus.wr_cnt_o), 256'(n_wr));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("stat_rst", 256'({bus.rd_cnt_o, bus.wr_cnt_o}), 256'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
